cp0_regfile: RTL

Coprocessor-0 register file and exception/interrupt arbiter for the 5-stage MIPS pipeline. It receives the ALU overflow (ExcCode 12) and the other exception codes collected through M stage, plus the six hardware interrupt lines. It raises `Req`, captures EPC, Cause and SR state, and services `mfc0`, `mtc0` and `eret`. It sits beside the M-stage pipeline register and is the consumer end of the ALU `over` signal.

---
 rtl/cp0_regfile_pkg.sv | 33 +++
 rtl/cp0_regfile.sv | 89 ++++++++
 2 files changed

// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and field positions
// used by the CP0 register file.
package cp0_defs;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IM_W     = 6;
  localparam int unsigned EXC_W    = 5;

  localparam logic [REG_AW-1:0] REG_SR    = 5'd12;
  localparam logic [REG_AW-1:0] REG_CAUSE = 5'd13;
  localparam logic [REG_AW-1:0] REG_EPC   = 5'd14;
  localparam logic [REG_AW-1:0] REG_PRID  = 5'd15;

  typedef enum logic [EXC_W-1:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int unsigned SR_IE_BIT     = 0;
  localparam int unsigned SR_EXL_BIT    = 1;
  localparam int unsigned SR_IM_LSB     = 10;
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_IP_LSB  = 10;
  localparam int unsigned CAUSE_BD_BIT  = 31;

  localparam logic [DATA_W-1:0] SR_WMASK  = 32'h0000_FC03;
  localparam logic [DATA_W-1:0] EPC_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/cp0_regfile.sv
// CP0 register file (SR, Cause, EPC, PRId) with the interrupt/exception
// request arbiter that flushes the pipeline and records the restart state.
module cp0_regfile
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID_VAL     = 32'h0000_7001,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] DOut,
  output logic [31:0] EPCOut,
  output logic [31:0] HandlerPC
);

  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] cause_q;
  logic [DATA_W-1:0] epc_q;
  logic [DATA_W-1:0] epc_src;
  logic [IM_W-1:0]   sr_im;
  logic              sr_exl;
  logic              sr_ie;
  logic              int_req;
  logic              exc_req;

  assign sr_im  = sr_q[SR_IM_LSB +: IM_W];
  assign sr_exl = sr_q[SR_EXL_BIT];
  assign sr_ie  = sr_q[SR_IE_BIT];

  // Interrupts and exceptions are both masked while a handler runs (EXL=1).
  assign int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (ExcCode != EXC_INT) & ~sr_exl;
  assign Req     = int_req | exc_req;

  // A delay-slot instruction restarts at its branch.
  assign epc_src = BD ? (PC - 32'd4) : PC;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      cause_q[CAUSE_IP_LSB +: IM_W] <= HWInt;
      if (Req) begin
        sr_q[SR_EXL_BIT]                <= 1'b1;
        cause_q[CAUSE_EXC_LSB +: EXC_W] <= int_req ? EXC_INT : ExcCode;
        cause_q[CAUSE_BD_BIT]           <= BD;
        epc_q                           <= epc_src & EPC_MASK;
      end else begin
        if (WE && (A == REG_SR)) begin
          sr_q <= DIn & SR_WMASK;
        end
        // Placed after the SR write so eret's EXL clear wins over DIn[1].
        if (EXLClr) begin
          sr_q[SR_EXL_BIT] <= 1'b0;
        end
        if (WE && (A == REG_EPC)) begin
          epc_q <= DIn & EPC_MASK;
        end
      end
    end
  end

  // mfc0 read port; no bypass from a same-cycle mtc0.
  always_comb begin
    DOut = '0;
    case (A)
      REG_SR:    DOut = sr_q;
      REG_CAUSE: DOut = cause_q;
      REG_EPC:   DOut = epc_q;
      REG_PRID:  DOut = PRID_VAL;
      default:   DOut = '0;
    endcase
  end

  assign EPCOut    = epc_q;
  assign HandlerPC = HANDLER_ADDR;

endmodule
